// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the AD7476-style ADC sampler.
//   ADC_FRAME_BITS   : SCLK rising edges per conversion frame
//   ADC_LEAD_BITS    : leading bits the ADC drives as zero
//   ADC_SAMPLE_WIDTH : conversion result width
//   adc_state_e      : frame sequencer states
package adc_pkg;

  localparam int unsigned ADC_FRAME_BITS   = 16;
  localparam int unsigned ADC_LEAD_BITS    = 4;
  localparam int unsigned ADC_SAMPLE_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    QUIET = 2'd2
  } adc_state_e;

endpackage

// File: rtl/adc_sample_timer.sv
// Conversion-rate timer: free-runs 0..SAMPLE_PERIOD-1 while enabled, held at
// zero while disabled, so the first tick lands on the first enabled cycle.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   enable  : run the timer
//   tick    : high on every enabled cycle where the timer is zero
module adc_sample_timer #(
  parameter int unsigned SAMPLE_PERIOD = 2268
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned TIMER_W = $clog2(SAMPLE_PERIOD);

  logic [TIMER_W-1:0] r_timer;

  // Period counter with wrap; cleared whenever enable is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (!enable) begin
      r_timer <= '0;
    end else if (r_timer == TIMER_W'(SAMPLE_PERIOD - 1)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  assign tick = enable && (r_timer == '0);

endmodule

// File: rtl/adc_sampler.sv
// SPI master for a 12-bit AD7476-style serial ADC. Each tick starts a
// 16-clock frame (4 leading zeros, MSB first); the result is presented as a
// one-cycle adc_sample/adc_valid strobe. No backpressure downstream.
//   clock      : system clock
//   reset_n    : asynchronous active-low reset
//   enable     : run conversions while high
//   adc_sdata  : serial data from ADC
//   adc_cs_n   : ADC chip select, active low
//   adc_sclk   : ADC serial clock, idles high
//   adc_sample : last converted sample (held between strobes)
//   adc_valid  : one-cycle strobe, adc_sample updated this cycle
//   lead_err   : one-cycle strobe with adc_valid when a leading bit was 1
// Build option: define ADC_SIGNED_EN to emit two's complement samples
// (MSB inverted) instead of raw straight binary. Timing is unchanged.
module adc_sampler
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 2268
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        adc_sdata,
  output logic                        adc_cs_n,
  output logic                        adc_sclk,
  output logic [ADC_SAMPLE_WIDTH-1:0] adc_sample,
  output logic                        adc_valid,
  output logic                        lead_err
);

  localparam int unsigned CNT_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned EDGE_W = $clog2(ADC_FRAME_BITS + 1);

  // Configuration guard: a frame plus the quiet gap must fit in one period.
  if (CLK_DIV < 2) begin : g_bad_div
    $fatal(1, "adc_sampler: CLK_DIV must be >= 2");
  end
  if (SAMPLE_PERIOD < 2 * CLK_DIV * ADC_FRAME_BITS + 2 * CLK_DIV + 2) begin : g_bad_period
    $fatal(1, "adc_sampler: SAMPLE_PERIOD too short for one frame");
  end

  adc_state_e                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [EDGE_W-1:0]           r_edges;
  logic [ADC_FRAME_BITS-1:0]   r_shift;
  logic                        r_sdata;
  logic                        w_tick;
  logic                        w_lead;
  logic [ADC_SAMPLE_WIDTH-1:0] w_sample;

  adc_sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (w_tick)
  );

  // Serial input register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sdata <= 1'b0;
    end else begin
      r_sdata <= adc_sdata;
    end
  end

  assign w_lead = |r_shift[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS];

`ifdef ADC_SIGNED_EN
  // Offset binary to two's complement.
  assign w_sample = {~r_shift[ADC_SAMPLE_WIDTH-1], r_shift[ADC_SAMPLE_WIDTH-2:0]};
`else
  assign w_sample = r_shift[ADC_SAMPLE_WIDTH-1:0];
`endif

  // Frame sequencer, SCLK divider and deserialiser.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_edges    <= '0;
      r_shift    <= '0;
      adc_cs_n   <= 1'b1;
      adc_sclk   <= 1'b1;
      adc_sample <= '0;
      adc_valid  <= 1'b0;
      lead_err   <= 1'b0;
    end else begin
      adc_valid <= 1'b0;
      lead_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          r_cnt    <= '0;
          r_edges  <= '0;
          if (w_tick) begin
            adc_cs_n <= 1'b0;
            r_state  <= FRAME;
          end
        end
        FRAME: begin
          if (r_edges == EDGE_W'(ADC_FRAME_BITS)) begin
            // All bits in: close the frame and publish the result.
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b1;
            adc_sample <= w_sample;
            adc_valid  <= 1'b1;
            lead_err   <= w_lead;
            r_cnt      <= '0;
            r_state    <= QUIET;
          end else if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
            r_cnt    <= '0;
            adc_sclk <= ~adc_sclk;
            // Low-to-high transition: capture one bit, MSB first.
            if (!adc_sclk) begin
              r_shift <= {r_shift[ADC_FRAME_BITS-2:0], r_sdata};
              r_edges <= r_edges + EDGE_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        QUIET: begin
          // Minimum CS_n high time before the next conversion may start.
          if (r_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Directed self-checking bench for adc_sampler (CLK_DIV=4, SAMPLE_PERIOD=200).
// Inputs are driven and outputs sampled on the falling clock edge; "cycle k"
// counts falling edges after the cycle where enable was raised.
module tb_adc_sampler;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned SAMPLE_PERIOD = 200;

`ifdef ADC_SIGNED_EN
  localparam logic [11:0] E_ABC = 12'h2BC;
  localparam logic [11:0] E_123 = 12'h923;
  localparam logic [11:0] E_FFF = 12'h7FF;
  localparam logic [11:0] E_000 = 12'h800;
  localparam logic [11:0] E_321 = 12'hB21;
  localparam logic [11:0] E_555 = 12'hD55;
`else
  localparam logic [11:0] E_ABC = 12'hABC;
  localparam logic [11:0] E_123 = 12'h123;
  localparam logic [11:0] E_FFF = 12'hFFF;
  localparam logic [11:0] E_000 = 12'h000;
  localparam logic [11:0] E_321 = 12'h321;
  localparam logic [11:0] E_555 = 12'h555;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        adc_sdata = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] adc_sample;
  logic        adc_valid;
  logic        lead_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] word     = 16'h0000;

  always #5 clock = ~clock;

  adc_sampler #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .adc_sdata (adc_sdata),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_sample(adc_sample),
    .adc_valid (adc_valid),
    .lead_err  (lead_err)
  );

  // ADC model: MSB appears when CS_n falls, next bit after each SCLK rise.
  logic m_prev_cs   = 1'b1;
  logic m_prev_sclk = 1'b1;
  int   m_idx       = 0;
  always @(posedge clock) begin
    #1;
    if (m_prev_cs && !adc_cs_n) begin
      m_idx     = 15;
      adc_sdata = word[15];
    end else if (!adc_cs_n && !m_prev_sclk && adc_sclk && m_idx > 0) begin
      m_idx     = m_idx - 1;
      adc_sdata = word[m_idx];
    end
    m_prev_cs   = adc_cs_n;
    m_prev_sclk = adc_sclk;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); else n_pass++;
    n_checks++; if (adc_sclk !== 1'b1) $display("FAIL reset_sclk: got %b expected 1", adc_sclk); else n_pass++;
    n_checks++; if (adc_sample !== 12'h000) $display("FAIL reset_sample: got %h expected 000", adc_sample); else n_pass++;
    n_checks++; if (adc_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", adc_valid); else n_pass++;
    n_checks++; if (lead_err !== 1'b0) $display("FAIL reset_lead: got %b expected 0", lead_err); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_frame(input logic [15:0] w, input logic [11:0] exp_s,
                            input logic exp_l, input string name);
    int   rises = 0;
    int   early = 0;
    logic prev;
    word = w;
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL %s idle_cs_n: got %b expected 1", name, adc_cs_n); else n_pass++;
    enable = 1'b1;
    @(negedge clock);
    n_checks++; if (adc_cs_n !== 1'b0) $display("FAIL %s cs_fall: got %b expected 0", name, adc_cs_n); else n_pass++;
    prev = adc_sclk;
    for (int k = 2; k <= 129; k++) begin
      @(negedge clock);
      if (adc_valid) early++;
      if (!prev && adc_sclk) rises++;
      prev = adc_sclk;
    end
    @(negedge clock);
    n_checks++; if (adc_valid !== 1'b1) $display("FAIL %s valid_t130: got %b expected 1", name, adc_valid); else n_pass++;
    n_checks++; if (adc_sample !== exp_s) $display("FAIL %s sample: got %h expected %h", name, adc_sample, exp_s); else n_pass++;
    n_checks++; if (lead_err !== exp_l) $display("FAIL %s lead_err: got %b expected %b", name, lead_err, exp_l); else n_pass++;
    n_checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) $display("FAIL %s end_cs_sclk: got %b%b expected 11", name, adc_cs_n, adc_sclk); else n_pass++;
    n_checks++; if (rises != 16) $display("FAIL %s sclk_rises: got %0d expected 16", name, rises); else n_pass++;
    n_checks++; if (early != 0) $display("FAIL %s early_valid: got %0d expected 0", name, early); else n_pass++;
    @(negedge clock);
    n_checks++; if (adc_valid !== 1'b0 || lead_err !== 1'b0) $display("FAIL %s strobe_width: got %b%b expected 00", name, adc_valid, lead_err); else n_pass++;
    n_checks++; if (adc_sample !== exp_s) $display("FAIL %s sample_hold: got %h expected %h", name, adc_sample, exp_s); else n_pass++;
    enable = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_continuous();
    int   pulses = 0, last_k = -1, bad_space = 0, bad_width = 0, bad_sample = 0;
    int   frames = 0, fr_rises = 0, bad_rises = 0;
    int   high_run = 0, min_gap = 1000;
    logic seen_frame = 1'b0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
    word = 16'h0ABC;
    enable = 1'b1;
    for (int k = 1; k <= 935; k++) begin
      @(negedge clock);
      if (adc_valid) begin
        pulses++;
        if (last_k >= 0 && k - last_k != 200) bad_space++;
        last_k = k;
        if (adc_sample !== E_ABC) bad_sample++;
        if (prev_valid) bad_width++;
      end
      if (!adc_cs_n && !prev_sclk && adc_sclk) fr_rises++;
      if (prev_cs && !adc_cs_n && seen_frame && high_run < min_gap) min_gap = high_run;
      if (!prev_cs && adc_cs_n) begin
        frames++;
        seen_frame = 1'b1;
        if (fr_rises != 16) bad_rises++;
        fr_rises = 0;
      end
      high_run   = adc_cs_n ? high_run + 1 : 0;
      prev_cs    = adc_cs_n;
      prev_sclk  = adc_sclk;
      prev_valid = adc_valid;
    end
    n_checks++; if (pulses != 5) $display("FAIL cont_pulses: got %0d expected 5", pulses); else n_pass++;
    n_checks++; if (last_k != 930) $display("FAIL cont_last_pulse: got cycle %0d expected 930", last_k); else n_pass++;
    n_checks++; if (bad_space != 0) $display("FAIL cont_spacing: got %0d bad expected 0", bad_space); else n_pass++;
    n_checks++; if (bad_width != 0) $display("FAIL cont_width: got %0d bad expected 0", bad_width); else n_pass++;
    n_checks++; if (bad_sample != 0) $display("FAIL cont_sample: got %0d bad expected 0", bad_sample); else n_pass++;
    n_checks++; if (frames != 5 || bad_rises != 0) $display("FAIL cont_rises: got frames=%0d bad=%0d expected 5/0", frames, bad_rises); else n_pass++;
    n_checks++; if (min_gap < 8 || min_gap >= 1000) $display("FAIL cont_cs_gap: got %0d expected >=8", min_gap); else n_pass++;
    enable = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_enable_drop();
    int   valids = 0, valid_k = -1, falls_after = 0;
    logic prev_cs = 1'b1;
    word = 16'h0321;
    enable = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      if (adc_valid) begin
        valids++;
        valid_k = k;
      end
      if (k > 40 && prev_cs && !adc_cs_n) falls_after++;
      prev_cs = adc_cs_n;
      if (k == 40) enable = 1'b0;
    end
    n_checks++; if (valids != 1 || valid_k != 130) $display("FAIL drop_strobe: got %0d at %0d expected 1 at 130", valids, valid_k); else n_pass++;
    n_checks++; if (falls_after != 0) $display("FAIL drop_no_more_frames: got %0d expected 0", falls_after); else n_pass++;
    n_checks++; if (adc_sample !== E_321) $display("FAIL drop_sample: got %h expected %h", adc_sample, E_321); else n_pass++;
    enable = 1'b1;
    @(negedge clock);
    n_checks++; if (adc_cs_n !== 1'b0) $display("FAIL reenable_cs_fall: got %b expected 0", adc_cs_n); else n_pass++;
    repeat (129) @(negedge clock);
    n_checks++; if (adc_valid !== 1'b1) $display("FAIL reenable_valid: got %b expected 1", adc_valid); else n_pass++;
    enable = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset_midframe();
    int spurious = 0;
    word = 16'h0555;
    enable = 1'b1;
    repeat (61) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL midrst_cs_n: got %b expected 1", adc_cs_n); else n_pass++;
    n_checks++; if (adc_sclk !== 1'b1) $display("FAIL midrst_sclk: got %b expected 1", adc_sclk); else n_pass++;
    n_checks++; if (adc_sample !== 12'h000) $display("FAIL midrst_sample: got %h expected 000", adc_sample); else n_pass++;
    n_checks++; if (adc_valid !== 1'b0 || lead_err !== 1'b0) $display("FAIL midrst_strobes: got %b%b expected 00", adc_valid, lead_err); else n_pass++;
    repeat (3) begin
      @(negedge clock);
      if (adc_valid || !adc_cs_n) spurious++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++; if (adc_cs_n !== 1'b0) $display("FAIL postrst_cs_fall: got %b expected 0", adc_cs_n); else n_pass++;
    for (int k = 2; k <= 129; k++) begin
      @(negedge clock);
      if (adc_valid) spurious++;
    end
    n_checks++; if (spurious != 0) $display("FAIL midrst_spurious: got %0d expected 0", spurious); else n_pass++;
    @(negedge clock);
    n_checks++; if (adc_valid !== 1'b1) $display("FAIL postrst_valid: got %b expected 1", adc_valid); else n_pass++;
    n_checks++; if (adc_sample !== E_555) $display("FAIL postrst_sample: got %h expected %h", adc_sample, E_555); else n_pass++;
    enable = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_frame(16'h0ABC, E_ABC, 1'b0, "frame_0abc");
    test_frame(16'h8123, E_123, 1'b1, "frame_8123");
    test_frame(16'h0FFF, E_FFF, 1'b0, "frame_0fff");
    test_frame(16'h0000, E_000, 1'b0, "frame_0000");
    test_continuous();
    test_enable_drop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
